// File: rtl/pipeline_foreground_fetch.sv
// Fixed-latency foreground pixel fetch: one request slot per clock, one SRAM read per
// fetchable slot, response exactly FOREGROUND_FETCH_CYCLE_DELAY edges after the request.
module pipeline_foreground_fetch #(
  parameter int R_WIDTH                      = 5,
  parameter int G_WIDTH                      = 6,
  parameter int B_WIDTH                      = 5,
  parameter int PIXEL_SIZE                   = R_WIDTH + G_WIDTH + B_WIDTH,
  parameter int PRECISION                    = 11,
  parameter int RESOLUTION_X                 = 800,
  parameter int RESOLUTION_Y                 = 600,
  parameter int ADDR_WIDTH                   = 19,
  parameter int FG_BASE_ADDR                 = 0,
  parameter int SRAM_READ_LATENCY            = 3,
  parameter int FOREGROUND_FETCH_CYCLE_DELAY = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic signed [PRECISION:0]   req_x,
  input  logic signed [PRECISION:0]   req_y,
  input  logic                        req_active,
  output logic                        sram_read_en,
  output logic [ADDR_WIDTH-1:0]       sram_addr,
  input  logic                        sram_grant,
  input  logic [PIXEL_SIZE-1:0]       sram_data,
  input  logic                        sram_data_valid,
  output logic [PIXEL_SIZE-1:0]       fg_pixel_out,
  output logic                        fg_pixel_skip,
  output logic                        fg_pixel_ready,
  output logic [15:0]                 miss_count,
  output logic                        error_sticky
);

  localparam int D  = FOREGROUND_FETCH_CYCLE_DELAY;
  localparam int L  = SRAM_READ_LATENCY;
  localparam int DL = D - L - 1;

  localparam logic signed [PRECISION:0] RES_X_S = (PRECISION+1)'(RESOLUTION_X);
  localparam logic signed [PRECISION:0] RES_Y_S = (PRECISION+1)'(RESOLUTION_Y);
  localparam logic [ADDR_WIDTH-1:0]     BASE_A  = ADDR_WIDTH'(FG_BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0]     RES_X_A = ADDR_WIDTH'(RESOLUTION_X);

  // Slot tags: bit k describes the request sampled k edges ago.
  logic [D-1:0] tag_valid;
  logic [D-1:0] tag_fetch;
  logic [D-1:1] tag_granted;

  // Captured read data only needs to exist from the capture edge onward.
  logic [PIXEL_SIZE-1:0] data_line [DL];
  logic [DL-1:0]         data_ok;

  logic                  fetchable;
  logic [ADDR_WIDTH-1:0] addr_calc;
  logic                  capture_hit;
  logic                  resp_ok;
  logic                  miss;

  always_comb begin
    fetchable = req_active
              && !req_x[PRECISION] && (req_x < RES_X_S)
              && !req_y[PRECISION] && (req_y < RES_Y_S);
    addr_calc = BASE_A
              + ADDR_WIDTH'(req_y[PRECISION-1:0]) * RES_X_A
              + ADDR_WIDTH'(req_x[PRECISION-1:0]);
  end

  assign capture_hit = tag_granted[L] & sram_data_valid;
  assign resp_ok     = tag_granted[D-1] & data_ok[DL-1];
  assign miss        = tag_fetch[D-1] & ~resp_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid    <= '0;
      tag_fetch    <= '0;
      tag_granted  <= '0;
      sram_read_en <= 1'b0;
      sram_addr    <= '0;
    end else begin
      tag_valid    <= {tag_valid[D-2:0], req_valid};
      tag_fetch    <= {tag_fetch[D-2:0], req_valid & fetchable};
      tag_granted  <= {tag_granted[D-2:1], tag_fetch[0] & sram_grant};
      sram_read_en <= req_valid & fetchable;
      if (req_valid && fetchable) begin
        sram_addr <= addr_calc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DL; k++) begin
        data_line[k] <= '0;
      end
      data_ok <= '0;
    end else begin
      data_line[0] <= capture_hit ? sram_data : '0;
      data_ok[0]   <= capture_hit;
      for (int k = 1; k < DL; k++) begin
        data_line[k] <= data_line[k-1];
        data_ok[k]   <= data_ok[k-1];
      end
    end
  end

  // Response stage; data arriving with no granted read due only flags an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fg_pixel_ready <= 1'b0;
      fg_pixel_skip  <= 1'b0;
      fg_pixel_out   <= '0;
      miss_count     <= '0;
      error_sticky   <= 1'b0;
    end else begin
      fg_pixel_ready <= tag_valid[D-1];
      fg_pixel_skip  <= tag_valid[D-1] & ~resp_ok;
      fg_pixel_out   <= resp_ok ? data_line[DL-1] : '0;
      if (miss && miss_count != 16'hFFFF) begin
        miss_count <= miss_count + 16'd1;
      end
      if (miss || (sram_data_valid && !tag_granted[L])) begin
        error_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_foreground_fetch.sv
// Directed bench for pipeline_foreground_fetch with a latency-3 SRAM model and
// a cycle-stamped response scoreboard.
module tb_pipeline_foreground_fetch;

  logic               clk;
  logic               rst;
  logic               req_valid;
  logic signed [11:0] req_x;
  logic signed [11:0] req_y;
  logic               req_active;
  logic               sram_read_en;
  logic [18:0]        sram_addr;
  logic               sram_grant;
  logic [15:0]        sram_data;
  logic               sram_data_valid;
  logic [15:0]        fg_pixel_out;
  logic               fg_pixel_skip;
  logic               fg_pixel_ready;
  logic [15:0]        miss_count;
  logic               error_sticky;

  typedef struct {
    int unsigned due;
    logic        skip;
    logic [15:0] pix;
  } exp_t;

  exp_t        sb[$];
  int unsigned edge_cnt;
  int unsigned read_cnt;
  int          n_checks;
  int          n_fails;
  int unsigned exp_miss;
  logic [18:0] deny_addr;
  logic [18:0] suppress_addr;
  logic        pv [3];
  logic [18:0] pa [3];

  pipeline_foreground_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_x           (req_x),
    .req_y           (req_y),
    .req_active      (req_active),
    .sram_read_en    (sram_read_en),
    .sram_addr       (sram_addr),
    .sram_grant      (sram_grant),
    .sram_data       (sram_data),
    .sram_data_valid (sram_data_valid),
    .fg_pixel_out    (fg_pixel_out),
    .fg_pixel_skip   (fg_pixel_skip),
    .fg_pixel_ready  (fg_pixel_ready),
    .miss_count      (miss_count),
    .error_sticky    (error_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_pix(input logic [18:0] a);
    return 16'(a ^ (a >> 3)) ^ 16'hA5C3;
  endfunction

  // SRAM model: a read accepted at edge A shows data_valid for sampling at edge A+3.
  assign sram_grant      = !(sram_read_en && sram_addr == deny_addr);
  assign sram_data_valid = pv[2] && (pa[2] != suppress_addr);
  assign sram_data       = pv[2] ? model_pix(pa[2]) : 16'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
      end
    end else begin
      pv[0] <= sram_read_en & sram_grant;
      pa[0] <= sram_addr;
      for (int i = 1; i < 3; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (!rst && sram_read_en) read_cnt <= read_cnt + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and compare whatever the DUT presents.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst) return;
    if (fg_pixel_ready) begin
      if (sb.size() == 0) begin
        check_output("unexpected_response", 32'(fg_pixel_ready), 32'd0);
      end else begin
        e = sb.pop_front();
        check_output("resp_edge", edge_cnt, e.due);
        check_output("resp_skip", 32'(fg_pixel_skip), 32'(e.skip));
        check_output("resp_pixel", 32'(fg_pixel_out), 32'(e.pix));
      end
    end else begin
      check_output("idle_outputs", {15'd0, fg_pixel_skip, fg_pixel_out}, 32'd0);
      if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
        e = sb.pop_front();
        check_output("missing_response", 32'(fg_pixel_ready), 32'd1);
      end
    end
  endtask

  task automatic apply_stimulus(input int x, input int y, input logic active);
    exp_t        e;
    logic        fetch;
    logic [18:0] a;
    fetch = active && x >= 0 && x < 800 && y >= 0 && y < 600;
    a     = 19'(y * 800 + x);
    req_valid  = 1'b1;
    req_x      = 12'(x);
    req_y      = 12'(y);
    req_active = active;
    e.due  = edge_cnt + 7;
    e.skip = !fetch || a == deny_addr || a == suppress_addr;
    e.pix  = e.skip ? 16'h0 : model_pix(a);
    if (fetch && e.skip) exp_miss++;
    sb.push_back(e);
    tick();
  endtask

  task automatic idle(input int n);
    req_valid  = 1'b0;
    req_active = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int unsigned rc;
    n_checks      = 0;
    n_fails       = 0;
    exp_miss      = 0;
    edge_cnt      = 0;
    read_cnt      = 0;
    deny_addr     = 19'h7FFFF;
    suppress_addr = 19'h7FFFF;
    req_valid     = 1'b0;
    req_x         = '0;
    req_y         = '0;
    req_active    = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_ready", 32'(fg_pixel_ready), 32'd0);
    check_output("reset_read_en", 32'(sram_read_en), 32'd0);
    check_output("reset_addr", 32'(sram_addr), 32'd0);
    check_output("reset_miss", 32'(miss_count), 32'd0);
    check_output("reset_sticky", 32'(error_sticky), 32'd0);
    rst = 1'b0;
    idle(2);

    $display("[TB] single fetch at (10,2)");
    apply_stimulus(10, 2, 1'b1);
    check_output("single_read_en", 32'(sram_read_en), 32'd1);
    check_output("single_addr", 32'(sram_addr), 32'd1610);
    req_valid = 1'b0;
    tick();
    check_output("single_read_en_drop", 32'(sram_read_en), 32'd0);
    idle(8);

    $display("[TB] out-of-range and inactive requests");
    rc = read_cnt;
    apply_stimulus(-1, 5, 1'b1);
    apply_stimulus(800, 5, 1'b1);
    apply_stimulus(5, 600, 1'b1);
    apply_stimulus(5, 5, 1'b0);
    idle(9);
    check_output("skip_no_reads", read_cnt - rc, 32'd0);

    $display("[TB] full line of back-to-back fetches");
    rc = read_cnt;
    for (int x = 0; x < 800; x++) apply_stimulus(x, 599, 1'b1);
    idle(9);
    check_output("line_reads", read_cnt - rc, 32'd800);
    check_output("line_miss", 32'(miss_count), 32'd0);
    check_output("line_sticky", 32'(error_sticky), 32'd0);

    $display("[TB] denied grant and suppressed data");
    deny_addr     = 19'd4003;
    suppress_addr = 19'd4006;
    for (int x = 0; x < 10; x++) apply_stimulus(x, 5, 1'b1);
    idle(9);
    check_output("fail_miss", 32'(miss_count), 32'(exp_miss));
    check_output("fail_miss_two", 32'(miss_count), 32'd2);
    check_output("fail_sticky", 32'(error_sticky), 32'd1);
    deny_addr     = 19'h7FFFF;
    suppress_addr = 19'h7FFFF;

    $display("[TB] reset with requests in flight");
    for (int x = 20; x < 24; x++) apply_stimulus(x, 1, 1'b1);
    idle(3);
    #2 rst = 1'b1;
    #1;
    check_output("midrst_ready", 32'(fg_pixel_ready), 32'd0);
    check_output("midrst_skip", 32'(fg_pixel_skip), 32'd0);
    check_output("midrst_pixel", 32'(fg_pixel_out), 32'd0);
    check_output("midrst_read_en", 32'(sram_read_en), 32'd0);
    check_output("midrst_miss", 32'(miss_count), 32'd0);
    check_output("midrst_sticky", 32'(error_sticky), 32'd0);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    idle(10);
    apply_stimulus(7, 3, 1'b1);
    idle(10);
    check_output("scoreboard_drained", sb.size(), 32'd0);
    check_output("final_sticky", 32'(error_sticky), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
